// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared ALU opcodes, ID/EX and EX/MEM field offsets, ALU function
`timescale 1ns/1ps
package execute_stage_pkg;

    localparam int MUL_CYCLES = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;
    localparam logic [3:0] ALU_MUL = 4'd11;

    // ID/EX field offsets
    localparam int IDEX_RD1_LSB   = 0;
    localparam int IDEX_RD2_LSB   = 32;
    localparam int IDEX_IMM_LSB   = 64;
    localparam int IDEX_RS_LSB    = 96;
    localparam int IDEX_RT_LSB    = 101;
    localparam int IDEX_RD_LSB    = 106;
    localparam int IDEX_REGDST    = 111;
    localparam int IDEX_ALUSRC    = 112;
    localparam int IDEX_ALUOP_LSB = 113;
    localparam int IDEX_MEMREAD   = 117;
    localparam int IDEX_MEMWRITE  = 118;
    localparam int IDEX_MEMTOREG  = 119;
    localparam int IDEX_REGWRITE  = 120;

    // EX/MEM field offsets
    localparam int EXMEM_RES_LSB   = 0;
    localparam int EXMEM_WDATA_LSB = 32;
    localparam int EXMEM_WREG_LSB  = 64;
    localparam int EXMEM_MEMREAD   = 71;
    localparam int EXMEM_MEMTOREG  = 72;
    localparam int EXMEM_MEMWRITE  = 73;
    localparam int EXMEM_REGWRITE  = 74;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    // Single-cycle ALU; MUL and unused opcodes return 0 here (MUL comes from the multiplier).
    function automatic logic [31:0] alu_compute(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  shamt
    );
        logic [31:0] r;
        r = 32'd0;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = b << shamt;
            ALU_SRL: r = b >> shamt;
            ALU_SUB: r = a - b;
            ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
            ALU_NOR: r = ~(a | b);
            ALU_SRA: r = $signed(b) >>> shamt;
            ALU_LUI: r = b << 16;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_stage_multiplier.sv
// rtl/execute_stage_multiplier.sv - iterative shift-add multiplier, one product bit per cycle, low 32 bits
`timescale 1ns/1ps
module iterative_multiplier
    import execute_stage_pkg::*;
#(
    parameter int N_CYCLES = MUL_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam int CW = $clog2(N_CYCLES + 1);

    mul_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   prod_q, prod_d;
    logic [31:0]   step_prod;

    // Product after the current step; the final step's value is handed out before it is registered.
    assign step_prod = prod_q + (b_q[0] ? a_q : 32'd0);
    assign busy_o    = (state_q == MUL_BUSY);
    assign done_o    = busy_o && (cnt_q == CW'(1));
    assign result_o  = step_prod;

    // Multiplier state registers; reset aborts any multiplication in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    // Next state: latch operands on start, then one shift-add step per cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    prod_d  = 32'd0;
                    cnt_d   = CW'(N_CYCLES);
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                prod_d = step_prod;
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: operand forwarding, ALU, iterative MUL with stall, EX/MEM register
`timescale 1ns/1ps
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [120:0] IDEXReg,
    input  logic         wbRegWrite,
    input  logic [4:0]   wbReg,
    input  logic [31:0]  wbData,
    output logic [74:0]  EXMEMReg,
    output logic         exStall
);

    logic [74:0] exmem_q, exmem_d;
    logic [31:0] mul_wdata_q, mul_wdata_d;

    logic [31:0] rd_data1, rd_data2, imm;
    logic [4:0]  rs, rt, rd, write_reg;
    logic [3:0]  alu_op;
    logic        is_mul;
    logic        ex_wr_en;
    logic [4:0]  ex_wr_reg;
    logic [31:0] ex_res;
    logic [31:0] fwd_a, fwd_b, op_b, alu_res;
    logic        mul_busy, mul_done;
    logic [31:0] mul_res;

    assign rd_data1  = IDEXReg[IDEX_RD1_LSB +: 32];
    assign rd_data2  = IDEXReg[IDEX_RD2_LSB +: 32];
    assign imm       = IDEXReg[IDEX_IMM_LSB +: 32];
    assign rs        = IDEXReg[IDEX_RS_LSB +: 5];
    assign rt        = IDEXReg[IDEX_RT_LSB +: 5];
    assign rd        = IDEXReg[IDEX_RD_LSB +: 5];
    assign alu_op    = IDEXReg[IDEX_ALUOP_LSB +: 4];
    assign is_mul    = (alu_op == ALU_MUL);
    assign write_reg = IDEXReg[IDEX_REGDST] ? rd : rt;

    assign ex_wr_en  = exmem_q[EXMEM_REGWRITE];
    assign ex_wr_reg = exmem_q[EXMEM_WREG_LSB +: 5];
    assign ex_res    = exmem_q[EXMEM_RES_LSB +: 32];

    // Operand forwarding: EX/MEM beats MEM/WB, register 0 never forwards
    always_comb begin
        fwd_a = rd_data1;
        fwd_b = rd_data2;
        if (ex_wr_en && (ex_wr_reg != 5'd0) && (ex_wr_reg == rs)) begin
            fwd_a = ex_res;
        end else if (wbRegWrite && (wbReg != 5'd0) && (wbReg == rs)) begin
            fwd_a = wbData;
        end
        if (ex_wr_en && (ex_wr_reg != 5'd0) && (ex_wr_reg == rt)) begin
            fwd_b = ex_res;
        end else if (wbRegWrite && (wbReg != 5'd0) && (wbReg == rt)) begin
            fwd_b = wbData;
        end
    end

    assign op_b    = IDEXReg[IDEX_ALUSRC] ? imm : fwd_b;
    assign alu_res = alu_compute(alu_op, fwd_a, op_b, imm[10:6]);

    iterative_multiplier #(
        .N_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (is_mul),
        .a_i      (fwd_a),
        .b_i      (op_b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    // Hold upstream from MUL issue until the final step; never while in reset
    assign exStall = !rst && is_mul && !mul_done;

    // Store data is captured at MUL start so forwarding-source changes during BUSY are ignored
    assign mul_wdata_d = (is_mul && !mul_busy) ? fwd_b : mul_wdata_q;

    // EX/MEM payload: ALU result, MUL result on its final step, otherwise a bubble during MUL
    always_comb begin
        exmem_d = '0;
        if (!is_mul) begin
            exmem_d = {IDEXReg[IDEX_REGWRITE], IDEXReg[IDEX_MEMWRITE], IDEXReg[IDEX_MEMTOREG],
                       IDEXReg[IDEX_MEMREAD], 2'b00, write_reg, fwd_b, alu_res};
        end else if (mul_done) begin
            exmem_d = {IDEXReg[IDEX_REGWRITE], IDEXReg[IDEX_MEMWRITE], IDEXReg[IDEX_MEMTOREG],
                       IDEXReg[IDEX_MEMREAD], 2'b00, write_reg, mul_wdata_q, mul_res};
        end
    end

    // EX/MEM pipeline register and latched MUL store data
    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_q     <= '0;
            mul_wdata_q <= '0;
        end else begin
            exmem_q     <= exmem_d;
            mul_wdata_q <= mul_wdata_d;
        end
    end

    assign EXMEMReg = exmem_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
`timescale 1ns/1ps
module tb_execute_stage;

    logic         clk;
    logic         rst;
    logic [120:0] IDEXReg;
    logic         wbRegWrite;
    logic [4:0]   wbReg;
    logic [31:0]  wbData;
    logic [74:0]  EXMEMReg;
    logic         exStall;

    int checks;
    int passed;

    execute_stage dut (
        .clk        (clk),
        .rst        (rst),
        .IDEXReg    (IDEXReg),
        .wbRegWrite (wbRegWrite),
        .wbReg      (wbReg),
        .wbData     (wbData),
        .EXMEMReg   (EXMEMReg),
        .exStall    (exStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [120:0] mk(
        input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic regdst, input logic alusrc, input logic [31:0] d1, input logic [31:0] d2,
        input logic [31:0] imm, input logic memread, input logic regwrite
    );
        return {regwrite, 1'b0, 1'b0, memread, op, alusrc, regdst, rd, rt, rs, imm, d2, d1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wbRegWrite = 1'b0; wbReg = 5'd0; wbData = 32'd0;
        IDEXReg = mk(4'd11, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (exStall !== 1'b0) $display("FAIL reset_stall: got %b want 0", exStall);
        else passed++;
        tick(); tick();
        checks++;
        if (EXMEMReg !== 75'd0) $display("FAIL reset_exmem: got %h want 0", EXMEMReg);
        else passed++;
    endtask

    task automatic test_add();
        rst = 1'b0;
        IDEXReg = mk(4'd2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (exStall !== 1'b0) $display("FAIL add_stall: got %b want 0", exStall);
        else passed++;
        tick();
        checks++;
        if (EXMEMReg[31:0] !== 32'd12) $display("FAIL add_result: got %h want 12", EXMEMReg[31:0]);
        else passed++;
        checks++;
        if (EXMEMReg[68:64] !== 5'd3 || EXMEMReg[74] !== 1'b1 || EXMEMReg[63:32] !== 32'd7)
            $display("FAIL add_fields: got wr=%0d rw=%b wd=%h want wr=3 rw=1 wd=7",
                     EXMEMReg[68:64], EXMEMReg[74], EXMEMReg[63:32]);
        else passed++;
    endtask

    task automatic test_forwarding();
        // SUB r4 = r3 - r3 with stale read data; EX/MEM holds r3=12
        IDEXReg = mk(4'd6, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 32'd100, 32'd50, 32'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (EXMEMReg[31:0] !== 32'd0) $display("FAIL fwd_exmem_sub: got %h want 0", EXMEMReg[31:0]);
        else passed++;
        // EX/MEM RegWrite=0 now; MEM/WB supplies r3=9
        wbRegWrite = 1'b1; wbReg = 5'd3; wbData = 32'd9;
        IDEXReg = mk(4'd6, 5'd3, 5'd6, 5'd4, 1'b1, 1'b0, 32'd100, 32'd2, 32'd0, 1'b0, 1'b1);
        tick();
        checks++;
        if (EXMEMReg[31:0] !== 32'd7) $display("FAIL fwd_memwb: got %h want 7", EXMEMReg[31:0]);
        else passed++;
        // Both stages hold r4; EX/MEM (7) must win over MEM/WB (1000)
        wbReg = 5'd4; wbData = 32'd1000;
        IDEXReg = mk(4'd2, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        tick();
        checks++;
        if (EXMEMReg[31:0] !== 32'd14) $display("FAIL fwd_priority: got %h want 14", EXMEMReg[31:0]);
        else passed++;
        // r0 written by EX/MEM and MEM/WB; reader of r0 must use read data
        wbReg = 5'd0; wbData = 32'd55;
        IDEXReg = mk(4'd2, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (EXMEMReg[31:0] !== 32'd7 || EXMEMReg[63:32] !== 32'd4)
            $display("FAIL fwd_r0: got res=%h wd=%h want res=7 wd=4", EXMEMReg[31:0], EXMEMReg[63:32]);
        else passed++;
        wbRegWrite = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        alusrc;
        logic [31:0] imm;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic test_alu_ops();
        alu_vec_t v[12];
        v[0]  = '{4'd7,  32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         32'h1};
        v[1]  = '{4'd9,  32'h0,         32'h8000_0000, 1'b0, 32'h100,       32'hF800_0000};
        v[2]  = '{4'd10, 32'h0,         32'h0,         1'b1, 32'h1234,      32'h1234_0000};
        v[3]  = '{4'd8,  32'h0,         32'h0,         1'b0, 32'h0,         32'hFFFF_FFFF};
        v[4]  = '{4'd0,  32'hF0F0,      32'hFF00,      1'b0, 32'h0,         32'hF000};
        v[5]  = '{4'd1,  32'hF0F0,      32'hFF00,      1'b0, 32'h0,         32'hFFF0};
        v[6]  = '{4'd3,  32'hF0F0,      32'hFF00,      1'b0, 32'h0,         32'h0FF0};
        v[7]  = '{4'd4,  32'h0,         32'h1,         1'b0, 32'h7C0,       32'h8000_0000};
        v[8]  = '{4'd5,  32'h0,         32'h8000_0000, 1'b0, 32'h100,       32'h0800_0000};
        v[9]  = '{4'd2,  32'hFFFF_FFFF, 32'h2,         1'b0, 32'h0,         32'h1};
        v[10] = '{4'd2,  32'd10,        32'h0,         1'b1, 32'hFFFF_FFFE, 32'd8};
        v[11] = '{4'd6,  32'd3,         32'd5,         1'b0, 32'h0,         32'hFFFF_FFFE};
        for (int i = 0; i < 12; i++) begin
            IDEXReg = mk(v[i].op, 5'd1, 5'd2, 5'd9, 1'b1, v[i].alusrc, v[i].a, v[i].b, v[i].imm, 1'b0, 1'b0);
            tick();
            checks++;
            if (EXMEMReg[31:0] !== v[i].exp)
                $display("FAIL alu_op%0d_vec%0d: got %h want %h", v[i].op, i, EXMEMReg[31:0], v[i].exp);
            else passed++;
        end
        // Unused opcode gives 0 but controls still pass through
        IDEXReg = mk(4'd12, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1);
        tick();
        checks++;
        if (EXMEMReg[31:0] !== 32'd0 || EXMEMReg[71] !== 1'b1 || EXMEMReg[74] !== 1'b1 || EXMEMReg[68:64] !== 5'd9)
            $display("FAIL alu_op12: got res=%h mr=%b rw=%b wr=%0d want res=0 mr=1 rw=1 wr=9",
                     EXMEMReg[31:0], EXMEMReg[71], EXMEMReg[74], EXMEMReg[68:64]);
        else passed++;
    endtask

    task automatic test_mul();
        int stall_cnt;
        int bubble_bad;
        logic last_stall;
        stall_cnt = 0; bubble_bad = 0; last_stall = 1'b1;
        IDEXReg = mk(4'd11, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'h0001_0003, 32'h10, 32'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            #1;
            if (exStall === 1'b1) stall_cnt++;
            if (k == 33) last_stall = exStall;
            tick();
            if (k <= 32 && EXMEMReg !== 75'd0) bubble_bad++;
            if (k == 5) begin
                wbRegWrite = 1'b1; wbReg = 5'd1; wbData = 32'hDEAD;
            end
        end
        wbRegWrite = 1'b0;
        checks++;
        if (stall_cnt !== 32) $display("FAIL mul_stall_count: got %0d want 32", stall_cnt);
        else passed++;
        checks++;
        if (last_stall !== 1'b0) $display("FAIL mul_last_stall: got %b want 0", last_stall);
        else passed++;
        checks++;
        if (bubble_bad !== 0) $display("FAIL mul_bubbles: got %0d non-bubble cycles want 0", bubble_bad);
        else passed++;
        checks++;
        if (EXMEMReg[31:0] !== 32'h0010_0030 || EXMEMReg[68:64] !== 5'd7 || EXMEMReg[74] !== 1'b1)
            $display("FAIL mul_result: got res=%h wr=%0d rw=%b want res=00100030 wr=7 rw=1",
                     EXMEMReg[31:0], EXMEMReg[68:64], EXMEMReg[74]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int stall_cnt;
        stall_cnt = 0;
        IDEXReg = mk(4'd11, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (exStall !== 1'b1) $display("FAIL b2b_restart_stall: got %b want 1", exStall);
        else passed++;
        for (int k = 1; k <= 33; k++) begin
            #1;
            if (exStall === 1'b1) stall_cnt++;
            tick();
        end
        checks++;
        if (stall_cnt !== 32 || EXMEMReg[31:0] !== 32'd42 || EXMEMReg[68:64] !== 5'd8)
            $display("FAIL b2b_result: got stalls=%0d res=%h wr=%0d want stalls=32 res=2a wr=8",
                     stall_cnt, EXMEMReg[31:0], EXMEMReg[68:64]);
        else passed++;
    endtask

    task automatic test_reset_mid_mul();
        IDEXReg = mk(4'd11, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (exStall !== 1'b0) $display("FAIL rstmul_stall_in_reset: got %b want 0", exStall);
        else passed++;
        tick();
        checks++;
        if (EXMEMReg !== 75'd0) $display("FAIL rstmul_exmem: got %h want 0", EXMEMReg);
        else passed++;
        rst = 1'b0;
        IDEXReg = mk(4'd2, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (exStall !== 1'b0) $display("FAIL rstmul_add_stall: got %b want 0", exStall);
        else passed++;
        tick();
        checks++;
        if (EXMEMReg[31:0] !== 32'd5 || EXMEMReg[68:64] !== 5'd6)
            $display("FAIL rstmul_add_result: got res=%h wr=%0d want res=5 wr=6", EXMEMReg[31:0], EXMEMReg[68:64]);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_add();
        test_forwarding();
        test_alu_ops();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time budget");
        $fatal(1);
    end

endmodule
